// File: rtl/seg_pkg.sv
// Shared types, constants and helpers for the 4-digit 7-segment scan driver.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned VALUE_W    = NUM_DIGITS * NIB_W;

    localparam logic [NUM_DIGITS-1:0] DIGIT_OFF = 4'b1111;

    typedef enum logic {
        BLANK,
        ON
    } slot_state_t;

    // One display word: per-digit decimal points above the hex value.
    typedef struct packed {
        logic [NUM_DIGITS-1:0] dp;
        logic [VALUE_W-1:0]    value;
    } disp_word_t;

    // Bit i set means digit i is a leading zero; digit 0 is never suppressed.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [VALUE_W-1:0] v);
        logic [NUM_DIGITS-1:0] m;
        m[3] = (v[15:12] == 4'h0);
        m[2] = m[3] && (v[11:8] == 4'h0);
        m[1] = m[2] && (v[7:4] == 4'h0);
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot timer: owns the in-slot counter, BLANK/ON phase and digit index.
module seg_slot_timer
    import seg_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] idx,
    output logic       slot_start_c,  // this cycle's edge starts a new slot
    output logic       on_en_c,       // this cycle's edge enters the ON phase
    output logic       frame_end      // last cycle of the frame
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    slot_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             frame_q, frame_d;

    // Phase sequencing and lookahead for the registered frame flag.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        slot_start_c = 1'b0;
        on_en_c      = 1'b0;
        unique case (state_q)
            BLANK: begin
                if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d = ON;
                    on_en_c = 1'b1;
                end
            end
            ON: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    state_d      = BLANK;
                    cnt_d        = '0;
                    idx_d        = idx_q + 2'd1;
                    slot_start_c = 1'b1;
                end
            end
            default: state_d = BLANK;
        endcase
        frame_d = (state_d == ON) && (cnt_d == CNT_W'(CLK_DIV - 1)) && (idx_d == 2'd3);
    end

    // Timer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
        end
    end

    assign idx       = idx_q;
    assign frame_end = frame_q;

endmodule

// File: rtl/seg_scan.sv
// Multiplexed scan driver: double-buffered display word, digit/nibble muxing.
module seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [VALUE_W-1:0]    VALUE,
    input  logic [NUM_DIGITS-1:0] DP_IN,
    input  logic                  LOAD,
    input  logic                  BLANK_LZ,
    output logic [NIB_W-1:0]      D,
    output logic                  DP,
    output logic [NUM_DIGITS-1:0] DIGIT,
    output logic                  FRAME
);

    logic [1:0] idx;
    logic [1:0] nidx;
    logic       slot_start_c;
    logic       on_en_c;
    logic       frame_end;

    seg_slot_timer #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk          (CLK),
        .rst          (RST),
        .idx          (idx),
        .slot_start_c (slot_start_c),
        .on_en_c      (on_en_c),
        .frame_end    (frame_end)
    );

    disp_word_t            pend_q, pend_d;
    logic                  pend_v_q, pend_v_d;
    disp_word_t            disp_q, disp_d;
    logic [NIB_W-1:0]      d_q, d_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] digit_q, digit_d;
    disp_word_t            incoming;
    logic [NUM_DIGITS-1:0] lz_c;

    assign incoming = '{dp: DP_IN, value: VALUE};
    assign lz_c     = lz_mask(disp_q.value);
    assign nidx     = idx + 2'd1;

    // Buffer swap at the frame wrap, output latching at slot and ON entry.
    always_comb begin
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        disp_d   = disp_q;
        d_d      = d_q;
        dp_d     = dp_q;
        digit_d  = digit_q;

        if (frame_end) begin
            // A load on the wrap cycle is newer than anything pending.
            if (LOAD) begin
                disp_d   = incoming;
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                disp_d   = pend_q;
                pend_v_d = 1'b0;
            end
        end else if (LOAD) begin
            pend_d   = incoming;
            pend_v_d = 1'b1;
        end

        if (slot_start_c) begin
            d_d     = disp_d.value[{nidx, 2'b00} +: NIB_W];
            dp_d    = disp_d.dp[nidx];
            digit_d = DIGIT_OFF;
        end else if (on_en_c) begin
            if (BLANK_LZ && lz_c[idx]) begin
                digit_d = DIGIT_OFF;
            end else begin
                digit_d = ~(NUM_DIGITS'(1) << idx);
            end
        end
    end

    // Buffer and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            disp_q   <= '0;
            d_q      <= '0;
            dp_q     <= 1'b0;
            digit_q  <= DIGIT_OFF;
        end else begin
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            disp_q   <= disp_d;
            d_q      <= d_d;
            dp_q     <= dp_d;
            digit_q  <= digit_d;
        end
    end

    assign D     = d_q;
    assign DP    = dp_q;
    assign DIGIT = digit_q;
    assign FRAME = frame_end;

endmodule

// File: doc/seg_scan.md
# seg_scan

Four-digit multiplexed scan driver for the 7-segment display; sits directly upstream of svn_seg. It holds a 16-bit hex value plus four decimal points and time-multiplexes them onto the shared nibble bus D and the active-low digit enables DIGIT. Blank intervals between digits prevent ghosting. A double-buffered display register makes updates take effect only at frame boundaries, so no frame shows a mix of old and new digits.

## Interface
- CLK_DIV, 50000: clock cycles per digit slot; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 500: cycles at the start of each slot with all digits off; must be at least 1.
- CLK  input  1  system clock; single clock domain.
- RST  input  1  reset; synchronous, active-high.
- VALUE  input  16  hex value to display; nibble i feeds digit i (digit 0 is rightmost).
- DP_IN  input  4  decimal-point request per digit, active-high.
- LOAD  input  1  one-cycle strobe; captures VALUE and DP_IN into the pending register.
- BLANK_LZ  input  1  when 1, leading-zero digits are suppressed.
- D  output  4  nibble for svn_seg.
- DP  output  1  decimal point for the active digit.
- DIGIT  output  4  digit enables, active-low; 4'b1111 means all off.
- FRAME  output  1  one-cycle pulse on the last cycle of each frame.

## Operation
- Registers:
  - pend (16+4 bits) and pend_v (1 bit).
  - disp (16+4 bits).
  - idx (2 bits).
  - cnt, sized for CLK_DIV.
  - state: BLANK or ON.
- Load: when LOAD=1, set pend to {DP_IN, VALUE} and pend_v to 1. If several LOADs arrive within one frame, the last one wins.
- Slot state machine, with cnt counting 0..CLK_DIV-1 within each slot:
  - BLANK: DIGIT=4'b1111. Move to ON when cnt reaches BLANK_CYCLES-1.
  - ON: DIGIT has bit idx low, all other bits high. At cnt=CLK_DIV-1, go to BLANK, clear cnt to 0, and increment idx (3 wraps to 0).
- Frame wrap, on the ON-to-BLANK transition with idx=3:
  - FRAME=1 on that cycle.
  - If pend_v=1, copy pend into disp and clear pend_v.
  - If LOAD is also asserted on that same cycle, the incoming VALUE/DP_IN bypass pend and go straight into disp, and pend_v ends at 0.
- Outputs for the next slot are registered on entry to BLANK: D = disp nibble[idx], DP = disp dp[idx]. D and DP hold their values for the whole slot.
- Leading-zero suppression: with BLANK_LZ=1, digit i (i ≥ 1) stays off (its DIGIT bit stays 1 during ON) when disp nibbles i..3 are all zero. Digit 0 is always shown. The decision is evaluated from disp, not pend.
- RST mid-frame aborts the scan immediately. The next cycle behaves exactly as after power-up reset.

## Timing
- Reset values:
  - Outputs: DIGIT=4'b1111, D=0, DP=0, FRAME=0.
  - Internal: state=BLANK, idx=0, cnt=0, disp=0, pend=0, pend_v=0.
- After RST deasserts, digit 0 is first enabled BLANK_CYCLES cycles later.
- Slot length is CLK_DIV cycles; frame length is 4·CLK_DIV cycles. Each digit's on-time is CLK_DIV−BLANK_CYCLES cycles.
- D/DP change only in the first cycle of BLANK, never while any DIGIT bit is low.
- LOAD-to-visible latency is bounded by one frame: the value appears in the BLANK slot of digit 0 after the next FRAME pulse.
- LOAD is accepted on every cycle. There is no backpressure.

## Structure
- Shared package seg_pkg holds:
  - NUM_DIGITS=4.
  - DIGIT_OFF=4'b1111.
  - The slot-state enum {BLANK, ON}.
  - The function computing the leading-zero mask from a 16-bit value.
- One sub-module, seg_slot_timer, owns cnt, state and idx. It outputs slot_start, on_en and frame_end.
- seg_scan holds the pend/disp buffering and output muxing. The top-level instantiates seg_scan followed by svn_seg.

## Test plan
All scenarios use CLK_DIV=8 and BLANK_CYCLES=2.
- Reset/idle: hold RST for 3 cycles, then release.
  - DIGIT stays 1111 for 2 cycles, then reads 1110 for 6 cycles.
  - D=0 throughout.
  - FRAME first pulses at cycle 31 after release.
- Scan order: LOAD VALUE=16'h1234, DP_IN=4'b0100 during the first frame.
  - From the second frame on, (DIGIT, D) runs (1110,4), (1101,3), (1011,2), (0111,1).
  - DP=1 only while DIGIT=1011.
- Tear-free update: LOAD 16'hAAAA mid-frame, then LOAD 16'h5555 three cycles later.
  - The current frame still shows the old value.
  - The next frame shows 5555 on all digits; AAAA never appears.
- Simultaneous: LOAD 16'hBEEF on the exact FRAME cycle.
  - The following frame shows F, E, E, B.
  - pend_v=0 afterwards.
- Leading zeros: BLANK_LZ=1, VALUE=16'h0070.
  - Digits 0 and 1 are enabled in their ON phases.
  - Digits 2 and 3 keep DIGIT bits at 1 for the whole frame.
  - With VALUE=0, only digit 0 is shown, with D=0.
- Reset mid-scan: assert RST while DIGIT=1011.
  - The next cycle gives DIGIT=1111, D=0, disp=0.
  - Scanning restarts at digit 0.
